// File: rtl/m_mcctl_pkg.sv
// Shared constants for the multi-cycle add-only core: state codes, instruction fields,
// register indices and the decoded-instruction record.
package m_mcctl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;
  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [6:0] FUNCT7_ADD = 7'b0000000;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_HALT = 5'd30;

  localparam int ICNT_W_DEF = 16;

  typedef struct packed {
    logic       legal;
    logic [4:0] rd;
    logic       is_halt;
  } dec_t;

  function automatic logic is_legal_add(input logic [31:0] ir);
    return (ir[6:0] == OPCODE_OP) && (ir[14:12] == FUNCT3_ADD) && (ir[31:25] == FUNCT7_ADD);
  endfunction

endpackage

// File: rtl/m_mcctl_if.sv
// Control/status bundle between the multi-cycle controller (slave) and the
// datapath/bench side (master).
interface m_mcctl_if import m_mcctl_pkg::*; #(parameter int ICNT_W = ICNT_W_DEF) ();

  logic              w_start;
  logic              w_mem_rdy;
  logic [31:0]       w_ir;
  logic              w_ir_we;
  logic              w_pc_we;
  logic              w_alu_sel;
  logic              w_rf_we;
  logic              w_busy;
  logic              w_halt;
  logic              w_err;
  logic [2:0]        w_state;
  logic [ICNT_W-1:0] w_icount;

  modport master (
    output w_start, w_mem_rdy, w_ir,
    input  w_ir_we, w_pc_we, w_alu_sel, w_rf_we, w_busy, w_halt, w_err, w_state, w_icount
  );

  modport slave (
    input  w_start, w_mem_rdy, w_ir,
    output w_ir_we, w_pc_we, w_alu_sel, w_rf_we, w_busy, w_halt, w_err, w_state, w_icount
  );

endinterface

// File: rtl/m_mcctl_dec.sv
// Combinational instruction decode: add-legality, destination register and
// whether the write targets the halt register.
module m_mcctl_dec import m_mcctl_pkg::*; #(
  parameter logic [4:0] HALT_REG = REG_HALT
) (
  input  logic [31:0] ir,
  output dec_t        dec
);

  // rs1/rs2 are routed straight to the register file by the datapath
  logic unused_rs_s;
  assign unused_rs_s = ^ir[24:15];

  // field extraction and legality
  always_comb begin
    dec         = '{legal: 1'b0, rd: 5'd0, is_halt: 1'b0};
    dec.legal   = is_legal_add(ir);
    dec.rd      = ir[11:7];
    dec.is_halt = (ir[11:7] == HALT_REG);
  end

endmodule

// File: rtl/m_mcctl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer sharing one adder between PC+4 and rs1+rs2;
// halts sticky on a halt-register write, an illegal instruction or a fetch timeout.
module m_mcctl import m_mcctl_pkg::*; #(
  parameter int         ICNT_W   = ICNT_W_DEF,
  parameter int         WAIT_MAX = 15,
  parameter logic [4:0] HALT_REG = REG_HALT
) (
  input logic      w_clk,
  input logic      w_rst_n,
  m_mcctl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam logic [ICNT_W-1:0] ICNT_SAT  = {ICNT_W{1'b1}};

  logic [2:0]        state_r, state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [ICNT_W-1:0] icount_r, icount_nxt_s;
  logic              halt_r, halt_nxt_s;
  logic              err_r, err_nxt_s;
  logic              ir_we_s, pc_we_s, alu_sel_s, rf_we_s, busy_s;
  dec_t              dec_s;

  m_mcctl_dec #(.HALT_REG(HALT_REG)) u_dec (
    .ir  (bus.w_ir),
    .dec (dec_s)
  );

  // next-state, wait counter, retire counter and sticky flags
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    icount_nxt_s   = icount_r;
    halt_nxt_s     = halt_r;
    err_nxt_s      = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.w_start) state_nxt_s = ST_FETCH;
        else             state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.w_mem_rdy) begin
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
          state_nxt_s    = ST_DECODE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
          state_nxt_s    = ST_HALT;
          err_nxt_s      = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        if (dec_s.legal) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_HALT;
          err_nxt_s   = 1'b1;
        end
      end
      ST_EXEC: state_nxt_s = ST_WB;
      ST_WB: begin
        // rd=x0 still retires, so the count advances regardless of the write
        if (icount_r != ICNT_SAT) icount_nxt_s = icount_r + ICNT_W'(1);
        else                      icount_nxt_s = icount_r;
        if (dec_s.is_halt) begin
          state_nxt_s = ST_HALT;
          halt_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // enables decoded from state; IR/PC strobes follow memory-ready within FETCH
  always_comb begin
    ir_we_s   = 1'b0;
    pc_we_s   = 1'b0;
    alu_sel_s = 1'b0;
    rf_we_s   = 1'b0;
    busy_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        busy_s = 1'b1;
        if (bus.w_mem_rdy) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
        end else begin
          ir_we_s = 1'b0;
          pc_we_s = 1'b0;
        end
      end
      ST_DECODE: busy_s = 1'b1;
      ST_EXEC: begin
        busy_s    = 1'b1;
        alu_sel_s = 1'b1;
      end
      ST_WB: begin
        busy_s    = 1'b1;
        alu_sel_s = 1'b1;
        rf_we_s   = (dec_s.rd != REG_ZERO);
      end
      default: busy_s = 1'b0;
    endcase
  end

  // control state registers
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      icount_r   <= {ICNT_W{1'b0}};
      halt_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      icount_r   <= icount_nxt_s;
      halt_r     <= halt_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign bus.w_ir_we   = ir_we_s;
  assign bus.w_pc_we   = pc_we_s;
  assign bus.w_alu_sel = alu_sel_s;
  assign bus.w_rf_we   = rf_we_s;
  assign bus.w_busy    = busy_s;
  assign bus.w_halt    = halt_r;
  assign bus.w_err     = err_r;
  assign bus.w_state   = state_r;
  assign bus.w_icount  = icount_r;

endmodule

// File: tb/tb_m_mcctl.sv
// Self-checking bench for m_mcctl: each scenario builds an expected per-cycle trace from
// an instruction-level model and compares every DUT output on the falling edge.
module tb_m_mcctl;

  localparam int ICNT_W   = 16;
  localparam int WAIT_MAX = 15;

  // {icount, state, ir_we, pc_we, alu_sel, rf_we, busy, halt, err}
  typedef logic [ICNT_W+9:0] vec_t;

  logic w_clk = 1'b0;
  logic w_rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  vec_t              exp_q[$];
  logic              rdy_q[$];
  logic              start_q[$];
  logic [31:0]       ir_q[$];
  logic [ICNT_W-1:0] m_icount;
  logic              m_halt, m_err;

  m_mcctl_if #(.ICNT_W(ICNT_W)) bus ();

  m_mcctl #(.ICNT_W(ICNT_W), .WAIT_MAX(WAIT_MAX), .HALT_REG(5'd30)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  always #5 w_clk = ~w_clk;

  function automatic vec_t obs();
    return {bus.w_icount, bus.w_state, bus.w_ir_we, bus.w_pc_we, bus.w_alu_sel,
            bus.w_rf_we, bus.w_busy, bus.w_halt, bus.w_err};
  endfunction

  function automatic vec_t mk(input logic [2:0] st, input logic irwe, input logic pcwe,
                              input logic alu, input logic rf, input logic busy);
    return {m_icount, st, irwe, pcwe, alu, rf, busy, m_halt, m_err};
  endfunction

  task automatic qpush(input logic rdy, input logic st, input logic [31:0] ir, input vec_t v);
    rdy_q.push_back(rdy);
    start_q.push_back(st);
    ir_q.push_back(ir);
    exp_q.push_back(v);
  endtask

  task automatic reset_dut();
    w_rst_n       = 1'b0;
    bus.w_start   = 1'b0;
    bus.w_mem_rdy = 1'b0;
    bus.w_ir      = 32'h0;
    repeat (2) @(negedge w_clk);
    w_rst_n  = 1'b1;
    m_icount = '0;
    m_halt   = 1'b0;
    m_err    = 1'b0;
    exp_q.delete(); rdy_q.delete(); start_q.delete(); ir_q.delete();
    // idle cycle in which start is presented
    qpush(1'b1, 1'b1, 32'h0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Instruction-level model: expected cycles for one instruction after `stalls` not-ready fetches
  task automatic push_instr(input int stalls, input logic [31:0] ir);
    logic       legal;
    logic [4:0] rd;
    legal = (ir[6:0] == 7'b0110011) && (ir[14:12] == 3'b000) && (ir[31:25] == 7'b0000000);
    rd    = ir[11:7];
    for (int s = 0; s < stalls && s < WAIT_MAX; s++)
      qpush(1'b0, 1'b0, ir, mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    if (stalls >= WAIT_MAX) begin
      m_err = 1'b1;
      qpush(1'b0, 1'b0, ir, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      return;
    end
    qpush(1'b1, 1'b0, ir, mk(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    qpush(1'b1, 1'b0, ir, mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    if (!legal) begin
      m_err = 1'b1;
      qpush(1'b1, 1'b0, ir, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      return;
    end
    qpush(1'b1, 1'b0, ir, mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    qpush(1'b1, 1'b0, ir, mk(3'd4, 1'b0, 1'b0, 1'b1, (rd != 5'd0), 1'b1));
    if (m_icount != {ICNT_W{1'b1}}) m_icount = m_icount + 16'd1;
    if (rd == 5'd30) begin
      m_halt = 1'b1;
      qpush(1'b1, 1'b0, ir, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // halted cycles with start and ready both asserted: nothing may move
  task automatic push_halt_tail(input int n);
    for (int k = 0; k < n; k++)
      qpush(1'b1, 1'b1, 32'h00208F33, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic test_reset();
    w_rst_n       = 1'b0;
    bus.w_start   = 1'b0;
    bus.w_mem_rdy = 1'b1;
    bus.w_ir      = 32'h002082B3;
    @(negedge w_clk); #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL reset_hold: got %h want %h", obs(), vec_t'(0));
    end
    @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (2) @(negedge w_clk);
    #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL idle_no_start: got %h want %h", obs(), vec_t'(0));
    end
  endtask

  task automatic test_basic();
    reset_dut();
    push_instr(0, 32'h002082B3);
    foreach (exp_q[i]) begin
      @(negedge w_clk);
      bus.w_mem_rdy = rdy_q[i]; bus.w_start = start_q[i]; bus.w_ir = ir_q[i];
      #1; n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++; $display("FAIL basic cyc %0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
    @(negedge w_clk);
    bus.w_mem_rdy = 1'b0;
    #1; n_cmp++;
    if (obs() !== {16'd1, 3'd1, 7'b0000100}) begin
      n_err++; $display("FAIL basic_refetch: got %h want %h", obs(), {16'd1, 3'd1, 7'b0000100});
    end
  endtask

  task automatic test_stall();
    reset_dut();
    push_instr(3, 32'h002082B3);
    push_instr(0, 32'h00110233);
    foreach (exp_q[i]) begin
      @(negedge w_clk);
      bus.w_mem_rdy = rdy_q[i]; bus.w_start = start_q[i]; bus.w_ir = ir_q[i];
      #1; n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++; $display("FAIL stall cyc %0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    push_instr(WAIT_MAX - 1, 32'h002082B3);
    push_instr(WAIT_MAX, 32'h002082B3);
    push_halt_tail(3);
    foreach (exp_q[i]) begin
      @(negedge w_clk);
      bus.w_mem_rdy = rdy_q[i]; bus.w_start = start_q[i]; bus.w_ir = ir_q[i];
      #1; n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++; $display("FAIL timeout cyc %0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_halt_reg();
    reset_dut();
    push_instr(0, 32'h002082B3);
    push_instr(1, 32'h00208F33);
    push_halt_tail(4);
    foreach (exp_q[i]) begin
      @(negedge w_clk);
      bus.w_mem_rdy = rdy_q[i]; bus.w_start = start_q[i]; bus.w_ir = ir_q[i];
      #1; n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++; $display("FAIL halt_reg cyc %0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [4];
    bad[0] = 32'h00000013;
    bad[1] = 32'h40208033;
    bad[2] = 32'h0020C033;
    bad[3] = 32'h002082B7;
    for (int b = 0; b < 4; b++) begin
      reset_dut();
      push_instr(0, 32'h00208033);
      push_instr(0, bad[b]);
      push_halt_tail(2);
      foreach (exp_q[i]) begin
        @(negedge w_clk);
        bus.w_mem_rdy = rdy_q[i]; bus.w_start = start_q[i]; bus.w_ir = ir_q[i];
        #1; n_cmp++;
        if (obs() !== exp_q[i]) begin
          n_err++; $display("FAIL illegal[%0d] cyc %0d: got %h want %h", b, i, obs(), exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ir;
    int          rd, r, stalls;
    reset_dut();
    for (int n = 0; n < 30; n++) begin
      rd = $urandom_range(0, 30);
      if (rd == 30) rd = 31;
      ir = {7'b0000000, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'b000,
            5'(rd), 7'b0110011};
      r = $urandom_range(0, 9);
      if (r < 6)      stalls = 0;
      else if (r < 9) stalls = $urandom_range(1, 4);
      else            stalls = WAIT_MAX - 1;
      push_instr(stalls, ir);
    end
    foreach (exp_q[i]) begin
      @(negedge w_clk);
      bus.w_mem_rdy = rdy_q[i]; bus.w_start = start_q[i]; bus.w_ir = ir_q[i];
      #1; n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++; $display("FAIL random cyc %0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    push_instr(0, 32'h002082B3);
    foreach (exp_q[i]) begin
      @(negedge w_clk);
      bus.w_mem_rdy = rdy_q[i]; bus.w_start = start_q[i]; bus.w_ir = ir_q[i];
      #1; n_cmp++;
      if (obs() !== exp_q[i]) begin
        n_err++; $display("FAIL arst_pre cyc %0d: got %h want %h", i, obs(), exp_q[i]);
      end
    end
    repeat (3) @(negedge w_clk);
    #1; n_cmp++;
    if (bus.w_state !== 3'd3) begin
      n_err++; $display("FAIL arst_in_exec: got state %0d want 3", bus.w_state);
    end
    #1;
    w_rst_n = 1'b0;
    #1; n_cmp++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL arst_immediate: got %h want %h", obs(), vec_t'(0));
    end
    @(negedge w_clk);
    w_rst_n = 1'b1; bus.w_start = 1'b1; bus.w_mem_rdy = 1'b1;
    #1; n_cmp++;
    if (obs() !== '0) begin
      n_err++; $display("FAIL arst_idle: got %h want %h", obs(), vec_t'(0));
    end
    @(negedge w_clk);
    bus.w_start = 1'b0;
    #1; n_cmp++;
    if (obs() !== {16'd0, 3'd1, 7'b1100100}) begin
      n_err++; $display("FAIL arst_fetch: got %h want %h", obs(), {16'd0, 3'd1, 7'b1100100});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_halt_reg();
    test_illegal();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
